// File: rtl/hs_rx_sink.sv
// Four-phase handshake receiver: synchronizes a remote request, captures bundled
// data into a small FIFO and presents it on a valid/ready stream.
module hs_rx_sink #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_a,
    input  logic                     rst_n,
    input  logic                     req_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack_out,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               rx_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic              req_meta_q, req_s_q;
    logic              ack_q, ack_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [7:0]        rx_count_q, rx_count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              push, pop;

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= req_in;
            req_s_q    <= req_meta_q;
        end
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Fullness uses the registered level, so a same-cycle pop cannot release a stall.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s_q && (level_q != FULL_LVL)) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign pop = (level_q != '0) && out_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rx_count_d = rx_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            rx_count_d      = rx_count_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_count_q <= rx_count_d;
            mem_q      <= mem_d;
        end
    end

    assign ack_out    = ack_q;
    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign rx_count   = rx_count_q;

endmodule

// File: tb/tb_hs_rx_sink.sv
// Bench for hs_rx_sink: directed handshake scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_hs_rx_sink;

    localparam int DW = 4;
    localparam int DP = 4;

    logic          clk_a     = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_in    = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_in   = '0;
    logic          ack_out;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    fifo_level;
    logic [7:0]    rx_count;

    int compared   = 0;
    int mismatched = 0;

    hs_rx_sink #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk_a      (clk_a),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .rx_count   (rx_count)
    );

    always #5 clk_a = ~clk_a;

    // Reference: request seen two edges late; one word per request pulse while room exists.
    bit            m_r1  = 1'b0;
    bit            m_r2  = 1'b0;
    bit            m_ack = 1'b0;
    logic [DW-1:0] m_q[$];
    logic [7:0]    m_cnt = 8'd0;

    always @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            m_r1 = 1'b0;
            m_r2 = 1'b0;
            m_ack = 1'b0;
            m_q.delete();
            m_cnt = 8'd0;
        end else begin
            bit rs;
            bit accept;
            int sz;
            rs = m_r2;
            sz = m_q.size();
            accept = rs && !m_ack && (sz < DP);
            if (sz != 0 && out_ready) void'(m_q.pop_front());
            if (accept) begin
                m_q.push_back(data_in);
                m_cnt = m_cnt + 8'd1;
            end
            m_ack = rs && (m_ack || accept);
            m_r2 = m_r1;
            m_r1 = req_in;
        end
    end

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if (ack_out !== 1'b0) begin mismatched++; $display("FAIL reset_ack: got %0b want 0", ack_out); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        compared++;
        if (fifo_level !== 3'd0) begin mismatched++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        compared++;
        if (rx_count !== 8'd0) begin mismatched++; $display("FAIL reset_rx: got %0d want 0", rx_count); end
        compared++;
        if (out_data !== 4'h0) begin mismatched++; $display("FAIL reset_data: got %h want 0", out_data); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        data_in = 4'hA;
        tick();
        req_in = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            compared++;
            if (ack_out !== (e == 3)) begin
                mismatched++; $display("FAIL single_ack_rise e%0d: got %0b want %0b", e, ack_out, (e == 3));
            end
        end
        compared++;
        if (out_valid !== 1'b1 || out_data !== 4'hA) begin
            mismatched++; $display("FAIL single_data: got v=%0b d=%h want v=1 d=a", out_valid, out_data);
        end
        compared++;
        if (rx_count !== 8'd1 || fifo_level !== 3'd1) begin
            mismatched++; $display("FAIL single_count: got rx=%0d lvl=%0d want rx=1 lvl=1", rx_count, fifo_level);
        end
        req_in = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            compared++;
            if (ack_out !== (e < 3)) begin
                mismatched++; $display("FAIL single_ack_fall e%0d: got %0b want %0b", e, ack_out, (e < 3));
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            mismatched++; $display("FAIL single_pop: got v=%0b lvl=%0d want v=0 lvl=0", out_valid, fifo_level);
        end
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            data_in = DW'(k);
            tick();
            req_in = 1'b1;
            repeat (3) tick();
            compared++;
            if (ack_out !== (k <= 4) || fifo_level !== 3'((k <= 4) ? k : 4)) begin
                mismatched++;
                $display("FAIL fill_ack k%0d: got ack=%0b lvl=%0d want ack=%0b lvl=%0d",
                         k, ack_out, fifo_level, (k <= 4), (k <= 4) ? k : 4);
            end
            if (k <= 4) begin
                req_in = 1'b0;
                repeat (3) tick();
                compared++;
                if (ack_out !== 1'b0) begin mismatched++; $display("FAIL fill_ack_low k%0d: got %0b want 0", k, ack_out); end
            end
        end
        repeat (3) tick();
        compared++;
        if (ack_out !== 1'b0 || fifo_level !== 3'd4) begin
            mismatched++; $display("FAIL stall: got ack=%0b lvl=%0d want ack=0 lvl=4", ack_out, fifo_level);
        end
        compared++;
        if (out_data !== 4'h1) begin mismatched++; $display("FAIL stall_head: got %h want 1", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        compared++;
        if (ack_out !== 1'b0 || fifo_level !== 3'd3) begin
            mismatched++; $display("FAIL stall_pop_edge: got ack=%0b lvl=%0d want ack=0 lvl=3", ack_out, fifo_level);
        end
        tick();
        compared++;
        if (ack_out !== 1'b1 || fifo_level !== 3'd4) begin
            mismatched++; $display("FAIL stall_release: got ack=%0b lvl=%0d want ack=1 lvl=4", ack_out, fifo_level);
        end
        req_in = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        for (int w = 2; w <= 5; w++) begin
            compared++;
            if (out_valid !== 1'b1 || out_data !== DW'(w)) begin
                mismatched++; $display("FAIL fill_order: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, DW'(w));
            end
            tick();
        end
        out_ready = 1'b0;
        compared++;
        if (fifo_level !== 3'd0 || rx_count !== m_cnt) begin
            mismatched++; $display("FAIL fill_end: got lvl=%0d rx=%0d want lvl=0 rx=%0d", fifo_level, rx_count, m_cnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] w[3];
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) w[k] = DW'($urandom);
        for (int k = 0; k < 2; k++) begin
            data_in = w[k];
            tick();
            req_in = 1'b1;
            repeat (3) tick();
            req_in = 1'b0;
            repeat (3) tick();
        end
        data_in = w[2];
        tick();
        req_in = 1'b1;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        compared++;
        if (ack_out !== 1'b1 || fifo_level !== 3'd2 || out_data !== w[1]) begin
            mismatched++;
            $display("FAIL simul: got ack=%0b lvl=%0d d=%h want ack=1 lvl=2 d=%h", ack_out, fifo_level, out_data, w[1]);
        end
        req_in = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        compared++;
        if (out_data !== w[2]) begin mismatched++; $display("FAIL simul_next: got %h want %h", out_data, w[2]); end
        tick();
        out_ready = 1'b0;
        compared++;
        if (fifo_level !== 3'd0) begin mismatched++; $display("FAIL simul_drain: got %0d want 0", fifo_level); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w;
        int edges;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            w = DW'($urandom);
            data_in = w;
            tick();
            req_in = 1'b1;
            edges = 11;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (ack_out === 1'b1) begin edges = i; break; end
            end
            compared++;
            if (edges != 3) begin mismatched++; $display("FAIL wrap_latency n%0d: got %0d edges want 3", n, edges); end
            compared++;
            if (out_valid !== 1'b1 || out_data !== w) begin
                mismatched++; $display("FAIL wrap_data n%0d: got v=%0b d=%h want v=1 d=%h", n, out_valid, out_data, w);
            end
            req_in = 1'b0;
            edges = 11;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (ack_out === 1'b0) begin edges = i; break; end
            end
            compared++;
            if (edges != 3) begin mismatched++; $display("FAIL wrap_fall n%0d: got %0d edges want 3", n, edges); end
        end
        out_ready = 1'b0;
        compared++;
        if (rx_count !== 8'd0 || fifo_level !== 3'd0) begin
            mismatched++; $display("FAIL wrap_end: got rx=%0d lvl=%0d want rx=0 lvl=0", rx_count, fifo_level);
        end
    endtask

    task automatic test_reset_hold();
        out_ready = 1'b0;
        data_in = DW'($urandom);
        tick();
        req_in = 1'b1;
        repeat (3) tick();
        compared++;
        if (ack_out !== 1'b1 || fifo_level !== 3'd1) begin
            mismatched++; $display("FAIL rsthold_pre: got ack=%0b lvl=%0d want ack=1 lvl=1", ack_out, fifo_level);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (ack_out !== 1'b0 || fifo_level !== 3'd0 || out_valid !== 1'b0 || rx_count !== 8'd0) begin
            mismatched++;
            $display("FAIL rsthold_async: got ack=%0b lvl=%0d v=%0b rx=%0d want 0 0 0 0", ack_out, fifo_level, out_valid, rx_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            compared++;
            if (ack_out !== (e == 3)) begin
                mismatched++; $display("FAIL rsthold_reack e%0d: got %0b want %0b", e, ack_out, (e == 3));
            end
        end
        compared++;
        if (rx_count !== 8'd1 || fifo_level !== 3'd1) begin
            mismatched++; $display("FAIL rsthold_count: got rx=%0d lvl=%0d want rx=1 lvl=1", rx_count, fifo_level);
        end
        req_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_long_req();
        out_ready = 1'b0;
        data_in = DW'($urandom);
        tick();
        req_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            compared++;
            if (ack_out !== (e >= 3)) begin
                mismatched++; $display("FAIL long_ack e%0d: got %0b want %0b", e, ack_out, (e >= 3));
            end
        end
        compared++;
        if (rx_count !== 8'd2 || fifo_level !== 3'd2) begin
            mismatched++; $display("FAIL long_once: got rx=%0d lvl=%0d want rx=2 lvl=2", rx_count, fifo_level);
        end
        req_in = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            compared++;
            if (ack_out !== (e < 3)) begin
                mismatched++; $display("FAIL long_fall e%0d: got %0b want %0b", e, ack_out, (e < 3));
            end
        end
        compared++;
        if (fifo_level !== 3'd2) begin mismatched++; $display("FAIL long_level: got %0d want 2", fifo_level); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (!req_in && !ack_out && $urandom_range(0, 1) == 1) req_in = 1'b1;
            else if (req_in && ack_out && $urandom_range(0, 1) == 1) req_in = 1'b0;
            if (!req_in) data_in = DW'($urandom);
            tick();
            compared++;
            if (ack_out !== m_ack || fifo_level !== 3'(m_q.size()) || rx_count !== m_cnt
                || out_valid !== (m_q.size() != 0)) begin
                mismatched++;
                $display("FAIL rand_state c%0d: got ack=%0b lvl=%0d rx=%0d v=%0b want ack=%0b lvl=%0d rx=%0d v=%0b",
                         c, ack_out, fifo_level, rx_count, out_valid, m_ack, m_q.size(), m_cnt, (m_q.size() != 0));
            end
            if (m_q.size() != 0) begin
                compared++;
                if (out_data !== m_q[0]) begin
                    mismatched++; $display("FAIL rand_data c%0d: got %h want %h", c, out_data, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_simultaneous();
        test_wrap();
        test_reset_hold();
        test_long_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
